// File: rtl/jesd204b_rx_char_replacer.sv
// Purpose: JESD204B RX lane-0 octet tracker. Restores /F/ (K28.7) and /A/ (K28.3)
//          alignment characters to the data they replaced, marks frame/multiframe
//          starts, counts misplaced control characters and requests a relink.
// Latency: 1 cycle, i_data/i_charisk -> o_data/o_sof/o_somf/o_align_err.
// Backpressure: none; i_valid=0 cycles are skipped (no output, position holds).
//
// Ports:
//   i_dclk, i_rst_n          link clock, async active-low reset
//   i_link_ok                link core CGS/ILAS done (rises on a multiframe start)
//   i_valid/i_data/i_charisk 4 octets per word, octet 0 = [7:0] = earliest
//   o_valid/o_data           corrected word, zero when not valid
//   o_sof/o_somf             per-octet start-of-frame / start-of-multiframe
//   o_align_err              pulse: word held a misplaced or unknown K character
//   o_err_cnt                saturating errored-word count, cleared on link rise
//   o_relink_req             sticky until i_link_ok drops
module jesd204b_rx_char_replacer #(
    parameter int JESD_F          = 1,
    parameter int JESD_K          = 8,
    parameter int ERR_CNT_WIDTH   = 8,
    parameter int ALIGN_ERR_LIMIT = 3
) (
    input  logic                     i_dclk,
    input  logic                     i_rst_n,
    input  logic                     i_link_ok,
    input  logic                     i_valid,
    input  logic [31:0]              i_data,
    input  logic [3:0]               i_charisk,
    output logic                     o_valid,
    output logic [31:0]              o_data,
    output logic [3:0]               o_sof,
    output logic [3:0]               o_somf,
    output logic                     o_align_err,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
    output logic                     o_relink_req
);

    localparam int         FK       = JESD_F * JESD_K;
    localparam logic [7:0] POS_WRAP = 8'(FK - 4);
    localparam logic [7:0] POS_LAST = 8'(FK - 1);
    localparam logic [7:0] F_MASK   = 8'(JESD_F - 1);
    localparam logic [3:0] LIMIT    = 4'(ALIGN_ERR_LIMIT);

    localparam logic [7:0] K28_3 = 8'h7C;  // /A/
    localparam logic [7:0] K28_7 = 8'hFC;  // /F/

    // State
    logic [7:0]               pos_q, pos_d;
    logic [31:0]              prev_q, prev_d;      // last corrected output word
    logic                     link_q, link_d;
    logic                     mf_err_q, mf_err_d;  // current multiframe saw an error
    logic [3:0]               consec_q, consec_d;  // consecutive errored multiframes
    logic                     valid_q, valid_d;
    logic [31:0]              data_q, data_d;
    logic [3:0]               sof_q, sof_d;
    logic [3:0]               somf_q, somf_d;
    logic                     aerr_q, aerr_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     relink_q, relink_d;

    // Per-word decode
    logic        acc;
    logic        rise;
    logic        word_err;
    logic        at_wrap;
    logic [63:0] win;     // {current word, previous corrected word}
    logic [3:0]  rep;
    logic [3:0]  err;
    logic [3:0]  sof;
    logic [3:0]  somf;

    function automatic logic [7:0] octet_at(input logic [63:0] w, input int idx);
        return w[8*idx +: 8];
    endfunction

    assign acc  = i_link_ok & i_valid;
    assign rise = i_link_ok & ~link_q;

    // Octet j of the current word sits at window index j+4; its replacement
    // source p-F sits at j+4-F. Corrections are written back into the window
    // in octet order so that F=1 chains through already-corrected octets.
    always_comb begin
        win  = {i_data, prev_q};
        rep  = '0;
        err  = '0;
        sof  = '0;
        somf = '0;
        for (int j = 0; j < 4; j++) begin
            logic [7:0] p;
            logic       eof;
            logic       eomf;
            logic [7:0] oct;
            p    = pos_q + 8'(j);
            eof  = (p & F_MASK) == F_MASK;
            eomf = p == POS_LAST;
            oct  = octet_at(win, j + 4);
            sof[j]  = (p & F_MASK) == 8'd0;
            somf[j] = p == 8'd0;
            rep[j]  = i_charisk[j] & (((oct == K28_3) & eomf) |
                                      ((oct == K28_7) & eof & ~eomf));
            err[j]  = i_charisk[j] & ~rep[j];
            if (rep[j]) begin
                win[8*(j+4) +: 8] = octet_at(win, j + 4 - JESD_F);
            end
        end
    end

    assign word_err = acc & (|err);
    assign at_wrap  = acc & (pos_q == POS_WRAP);

    always_comb begin
        pos_d    = pos_q;
        prev_d   = prev_q;
        mf_err_d = mf_err_q;
        consec_d = consec_q;
        link_d   = i_link_ok;

        if (!i_link_ok) begin
            pos_d    = '0;
            prev_d   = '0;
            mf_err_d = 1'b0;
            consec_d = '0;
        end else if (acc) begin
            pos_d  = at_wrap ? 8'd0 : pos_q + 8'd4;
            prev_d = win[63:32];
            if (at_wrap) begin
                mf_err_d = 1'b0;
                if (mf_err_q | word_err) begin
                    consec_d = (consec_q == LIMIT) ? LIMIT : consec_q + 4'd1;
                end else begin
                    consec_d = '0;
                end
            end else begin
                mf_err_d = mf_err_q | word_err;
            end
        end

        // Cleared on the rise, but the rising word itself still counts.
        err_cnt_d = rise ? '0 : err_cnt_q;
        if (word_err && (err_cnt_d != '1)) begin
            err_cnt_d = err_cnt_d + 1'b1;
        end

        relink_d = i_link_ok & (relink_q | (consec_d == LIMIT));

        valid_d = acc;
        data_d  = acc ? win[63:32] : '0;
        sof_d   = acc ? sof : '0;
        somf_d  = acc ? somf : '0;
        aerr_d  = word_err;
    end

    always_ff @(posedge i_dclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pos_q     <= '0;
            prev_q    <= '0;
            link_q    <= 1'b0;
            mf_err_q  <= 1'b0;
            consec_q  <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            sof_q     <= '0;
            somf_q    <= '0;
            aerr_q    <= 1'b0;
            err_cnt_q <= '0;
            relink_q  <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            prev_q    <= prev_d;
            link_q    <= link_d;
            mf_err_q  <= mf_err_d;
            consec_q  <= consec_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sof_q     <= sof_d;
            somf_q    <= somf_d;
            aerr_q    <= aerr_d;
            err_cnt_q <= err_cnt_d;
            relink_q  <= relink_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_sof        = sof_q;
    assign o_somf       = somf_q;
    assign o_align_err  = aerr_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_relink_req = relink_q;

endmodule

// File: doc/jesd204b_rx_char_replacer.md
Name: jesd204b_rx_char_replacer

Overview:
- Sits directly downstream of the JESD204B RX link core (subclass 1), in the i_dclk domain.
- Consumes the 32-bit lane-0 word stream once the link core reports CGS/ILAS complete.
- Tracks frame and multiframe octet position, and undoes the transmitter's /F/ (K28.7) and /A/ (K28.3) alignment-character substitution (scrambling off).
- Flags misplaced control characters and raises a relink request to the link controller after repeated misalignment.

Parameters:
- JESD_F, 1: octets per frame; legal values 1, 2, 4.
- JESD_K, 8: frames per multiframe; JESD_F*JESD_K must be a multiple of 4 and ≤256.
- ERR_CNT_WIDTH, 8: width of the saturating error counter.
- ALIGN_ERR_LIMIT, 3: consecutive errored multiframes that trigger a relink request (1..15).

Ports:
- i_dclk  in  1  link clock (250 MHz); the only clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_link_ok  in  1  link core CGS/ILAS done. Rises with the first word of a multiframe.
- i_valid  in  1  input word qualifier. Tie to 1 if unused.
- i_data  in  32  four octets; octet 0, the earliest in time, is [7:0].
- i_charisk  in  4  per-octet K-character flag; bit j applies to octet j.
- o_valid  out  1  output word qualifier.
- o_data  out  32  corrected octets, same ordering as i_data.
- o_sof  out  4  per-octet start-of-frame marker.
- o_somf  out  4  per-octet start-of-multiframe marker.
- o_align_err  out  1  one-cycle pulse when any octet in the word is in error.
- o_err_cnt  out  ERR_CNT_WIDTH  saturating count of errored words.
- o_relink_req  out  1  sticky request to re-run link establishment.

Behaviour:
- Reset (async assert, sync release): all outputs 0; position counter 0; previous-word register 0; errored-multiframe counter 0.
- Position counter `pos` (0..F*K-1):
  - Advances by 4 on each cycle with i_link_ok & i_valid, and wraps from F*K-4 to 0.
  - Forced to 0 while i_link_ok=0.
- Octet j has index p = pos + j.
  - end-of-frame (EOF): p mod F = F-1.
  - end-of-multiframe (EOMF): p = F*K-1.
- Replacement:
  - Octet j is replaced by the output octet at index p-F in either of two cases:
    - i_charisk[j]=1, value 0x7C, and EOMF.
    - i_charisk[j]=1, value 0xFC, EOF, and not EOMF.
  - The octet at p-F may lie in the previous output word; hold it in a register.
  - Replacements chain: for F=1, octet j uses the already-corrected octet j-1.
  - Immediately after i_link_ok rises, the previous-word register reads 0.
- Error octet, any of:
  - i_charisk[j]=1 with 0x7C not at EOMF.
  - 0xFC not at EOF, or 0xFC at EOMF.
  - Any other K value.
  - An errored octet passes through unchanged.
- Latency: exactly 1 cycle.
  - o_valid = registered (i_link_ok & i_valid).
  - o_data, o_sof, o_somf and o_align_err are registered alongside o_valid.
  - o_data is 0 when o_valid=0.
- o_sof[j]=1 when p mod F = 0; o_somf[j]=1 when p = 0. Both are 0 when o_valid=0.
- o_err_cnt:
  - +1 per errored word; saturates at all-ones.
  - Cleared on the cycle i_link_ok rises.
- Multiframe error tracking:
  - A multiframe is errored if any of its words is errored.
  - At each wrap, errored multiframes increment the consecutive counter; clean multiframes clear it.
  - When the counter reaches ALIGN_ERR_LIMIT, o_relink_req sets.
  - o_relink_req stays set until i_link_ok=0; it then clears on the next cycle.
- i_valid=0 cycles: pos holds, nothing is emitted, error state is unchanged.
- i_link_ok falling mid-multiframe:
  - Next cycle: o_valid=0, pos=0, consecutive counter cleared.
  - o_err_cnt is retained until the next rise.
- Reset mid-operation: all state returns to reset values immediately.

Test Plan:
- Clean stream, F=1, K=8: words 0x04030201, 0x08070605, no K flags → o_data identical 1 cycle later; o_somf=0001 on word 0; o_sof=1111; o_align_err=0.
- /A/ replacement, F=1, K=8: word 1 = 0x7C070605 with charisk=1000 → o_data=0x07070605, no error.
- /F/ replacement across a word boundary, F=4, K=2: word 0 = 0x44332211; word 1 = 0xFC776655 with charisk=1000 and pos=4 (EOMF) → flagged as error, data unchanged. Repeat with K=4: word 1 at pos=4 is not EOMF → o_data=0x44776655.
- Misplaced /A/ for 3 consecutive multiframes (0x7C at octet 0, charisk=0001) → o_align_err pulses once per multiframe; o_err_cnt=3; o_relink_req rises after the third wrap; it clears one cycle after i_link_ok drops.
- i_valid gaps: insert 0 cycles between words → pos does not advance; o_somf still marks every second valid word (F=1, K=8).
- Reset and link drop: deassert i_rst_n mid-multiframe → all outputs 0 immediately. Drop i_link_ok → o_valid=0 next cycle; on the next rise, octet 0 is again marked o_somf.
